// File: rtl/ser_bit_stream_gen.sv
// Parallel-to-serial feeder: valid/ready word input, MSB-first gapless serial output.
// Optional even-parity bit per frame when SER_PARITY_EN is defined.
module ser_bit_stream_gen #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PARITY = 2'd2} state_t;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    even_parity = ^w;
  endfunction
`else
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
`endif

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             ser_out_r, ser_out_s;
  logic             ser_valid_r, ser_valid_s;
  logic             frame_done_r, frame_done_s;
  logic             din_ready_s;
  logic             accept_s;
`ifdef SER_PARITY_EN
  logic             parity_r, parity_s;
`endif

  // cnt_r is the index of the bit currently on ser_out; ready only when that bit ends a frame
  always_comb begin
    din_ready_s = 1'b0;
    case (state_r)
      ST_IDLE:   din_ready_s = 1'b1;
`ifdef SER_PARITY_EN
      ST_SHIFT:  din_ready_s = 1'b0;
      ST_PARITY: din_ready_s = 1'b1;
`else
      ST_SHIFT:  din_ready_s = (cnt_r == LAST_IDX);
`endif
      default:   din_ready_s = 1'b0;
    endcase
  end

  assign accept_s = din_valid & din_ready_s;

  // Next-state and next-output computation
  always_comb begin
    state_s      = state_r;
    shift_s      = shift_r;
    cnt_s        = cnt_r;
    ser_out_s    = IDLE_BIT;
    ser_valid_s  = 1'b0;
    frame_done_s = 1'b0;
`ifdef SER_PARITY_EN
    parity_s     = parity_r;
`endif
    if (accept_s) begin
      state_s     = ST_SHIFT;
      shift_s     = {din[WIDTH-2:0], 1'b0};
      cnt_s       = '0;
      ser_out_s   = din[WIDTH-1];
      ser_valid_s = 1'b1;
`ifdef SER_PARITY_EN
      parity_s    = even_parity(din);
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_SHIFT: begin
          if (cnt_r != LAST_IDX) begin
            shift_s     = {shift_r[WIDTH-2:0], 1'b0};
            cnt_s       = cnt_r + CW'(1);
            ser_out_s   = shift_r[WIDTH-1];
            ser_valid_s = 1'b1;
`ifdef SER_PARITY_EN
            frame_done_s = 1'b0;
`else
            frame_done_s = (cnt_r == PENULT_IDX);
`endif
          end else begin
            cnt_s   = '0;
            shift_s = '0;
`ifdef SER_PARITY_EN
            state_s      = ST_PARITY;
            ser_out_s    = parity_r;
            ser_valid_s  = 1'b1;
            frame_done_s = 1'b1;
`else
            state_s      = ST_IDLE;
`endif
          end
        end
`ifdef SER_PARITY_EN
        ST_PARITY: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end
`endif
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          shift_s = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= '0;
      cnt_r        <= '0;
      ser_out_r    <= IDLE_BIT;
      ser_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef SER_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      cnt_r        <= cnt_s;
      ser_out_r    <= ser_out_s;
      ser_valid_r  <= ser_valid_s;
      frame_done_r <= frame_done_s;
`ifdef SER_PARITY_EN
      parity_r     <= parity_s;
`endif
    end
  end

  assign din_ready  = din_ready_s;
  assign ser_out    = ser_out_r;
  assign ser_valid  = ser_valid_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ser_bit_stream_gen.sv
// Self-checking bench for ser_bit_stream_gen: queue-based frame model plus directed literal checks.
module tb_ser_bit_stream_gen;
  localparam int   WIDTH    = 8;
  localparam logic IDLE_BIT = 1'b0;
`ifdef SER_PARITY_EN
  localparam bit          PAR     = 1'b1;
  localparam logic [31:0] EXP_T1  = 32'h132;
  localparam logic [31:0] EXP_T2  = 32'h24012;
  localparam logic [31:0] EXP_T2D = 32'h201;
  localparam logic [31:0] EXP_T4  = 32'h102;
`else
  localparam bit          PAR     = 1'b0;
  localparam logic [31:0] EXP_T1  = 32'h99;
  localparam logic [31:0] EXP_T2  = 32'h9009;
  localparam logic [31:0] EXP_T2D = 32'h101;
  localparam logic [31:0] EXP_T4  = 32'h81;
`endif
  localparam int FL = WIDTH + (PAR ? 1 : 0);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             din_ready, ser_out, ser_valid, frame_done;

  int errors = 0;
  int checks = 0;

  ser_bit_stream_gen #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted word becomes a queue of {done,bit} entries, one per cycle
  logic [1:0] q[$];
  logic cur_v = 1'b0, cur_b = IDLE_BIT, cur_d = 1'b0;

  always @(posedge clk or negedge rst) begin
    logic rdy;
    logic [1:0] e;
    if (!rst) begin
      q.delete();
      cur_v = 1'b0; cur_b = IDLE_BIT; cur_d = 1'b0;
    end else begin
      rdy = !cur_v || cur_d;
      if (din_valid && rdy) begin
        for (int i = WIDTH - 1; i >= 0; i--) q.push_back({(i == 0) && !PAR, din[i]});
        if (PAR) q.push_back({1'b1, ^din});
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        cur_v = 1'b1; cur_b = e[0]; cur_d = e[1];
      end else begin
        cur_v = 1'b0; cur_b = IDLE_BIT; cur_d = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("ser_valid", ser_valid, cur_v);
    chk("ser_out", ser_out, cur_v ? cur_b : IDLE_BIT);
    chk("frame_done", frame_done, cur_d);
    chk("din_ready", din_ready, !cur_v || cur_d);
  end

  task automatic send(input logic [WIDTH-1:0] w);
    int n;
    @(negedge clk);
    din = w; din_valid = 1'b1; n = 0;
    while (!din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n, output logic [31:0] bits, output logic [31:0] dones,
                         output int gaps, output int readies);
    int waited;
    bits = '0; dones = '0; gaps = 0; readies = 0; waited = 0;
    @(negedge clk);
    while (!ser_valid && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (!ser_valid) begin
      chk("capture_timeout", 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        bits  = {bits[30:0], ser_out};
        dones = {dones[30:0], frame_done};
        if (!ser_valid) gaps++;
        if (din_ready) readies++;
      end
    end
  endtask

  initial begin
    logic [31:0] bits, dones;
    int gaps, readies;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ser_out", ser_out, IDLE_BIT);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_din_ready", din_ready, 1'b1);
    #1 rst = 1'b1;

    // Idle with no valid words
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("t3_idle", {din_ready, ser_valid, ser_out, frame_done}, {1'b1, 1'b0, IDLE_BIT, 1'b0});
    end

    // Single word
    send(8'h99);
    din_valid = 1'b0;
    capture(FL, bits, dones, gaps, readies);
    chk("t1_bits", bits, EXP_T1);
    chk("t1_done", dones, 32'h1);
    chk("t1_gaps", gaps, 0);
    @(negedge clk);
    #1;
    chk("t1_after_valid", ser_valid, 1'b0);
    chk("t1_after_out", ser_out, IDLE_BIT);

    // Back-to-back words
    fork
      begin
        send(8'h90);
        din = 8'h09;
        send(8'h09);
        din_valid = 1'b0;
      end
      capture(2 * FL, bits, dones, gaps, readies);
    join
    chk("t2_bits", bits, EXP_T2);
    chk("t2_done", dones, EXP_T2D);
    chk("t2_gaps", gaps, 0);
    chk("t2_readies", readies, 2);

    // Reset in the middle of a frame
    repeat (3) @(negedge clk);
    send(8'hFF);
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t4_rst_valid", ser_valid, 1'b0);
    chk("t4_rst_out", ser_out, IDLE_BIT);
    chk("t4_rst_done", frame_done, 1'b0);
    chk("t4_rst_ready", din_ready, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    send(8'h81);
    din_valid = 1'b0;
    capture(FL, bits, dones, gaps, readies);
    chk("t4_bits", bits, EXP_T4);
    chk("t4_gaps", gaps, 0);
    @(negedge clk);
    #1;
    chk("t4_after_valid", ser_valid, 1'b0);

    // Randomised traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      din = WIDTH'($urandom);
      din_valid = (i % 100 < 30) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b0;
        #4 rst = 1'b1;
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    repeat (FL + 3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
